// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores on a word array,
// completed through a one-cycle ready pulse after WAIT_CYCLES wait states.
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memwrite,
  input  logic        half,
  input  logic        b,
  input  logic        bunsigned,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] CodeIdle  = 2'b00;
  localparam logic [1:0] CodeStore = 2'b01;
  localparam logic [1:0] CodeLoad  = 2'b10;
  localparam logic [1:0] CodeIll   = 2'b11;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e state_q, state_d;
  logic [3:0]    cnt_q;
  logic [1:0]    code_q;
  logic          half_q, b_q, uns_q;
  logic [AW+1:0] adr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   readdata_q;

  logic [31:0] mem [DEPTH];

  // Upper address bits only select aliases of the same word.
  logic unused_adr;
  assign unused_adr = ^dataadr[31:AW+2];

  function automatic logic req_err(logic [1:0] code, logic h, logic bb, logic [1:0] lane);
    return (code == CodeIll) || (!bb && h && lane[0]) || (!bb && !h && (lane != 2'b00));
  endfunction

  // Live request while idle (WAIT_CYCLES=0 enters RESP from IDLE), held request otherwise.
  logic          in_idle;
  logic [1:0]    e_code;
  logic          e_half, e_b, e_uns;
  logic [AW+1:0] e_adr;
  assign in_idle = (state_q == StIdle);
  assign e_code  = in_idle ? memwrite : code_q;
  assign e_half  = in_idle ? half : half_q;
  assign e_b     = in_idle ? b : b_q;
  assign e_uns   = in_idle ? bunsigned : uns_q;
  assign e_adr   = in_idle ? dataadr[AW+1:0] : adr_q;

  // Load extraction and extension.
  logic [31:0] ld_word, ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  always_comb begin
    ld_word = mem[e_adr[AW+1:2]];
    ld_byte = 8'h00;
    unique case (e_adr[1:0])
      2'd0: ld_byte = ld_word[7:0];
      2'd1: ld_byte = ld_word[15:8];
      2'd2: ld_byte = ld_word[23:16];
      2'd3: ld_byte = ld_word[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = e_adr[1] ? ld_word[31:16] : ld_word[15:0];
    if (e_b) begin
      ld_ext = {{24{!e_uns && ld_byte[7]}}, ld_byte};
    end else if (e_half) begin
      ld_ext = {{16{!e_uns && ld_half[15]}}, ld_half};
    end else begin
      ld_ext = ld_word;
    end
  end

  // Store lane enables and replicated data.
  logic [3:0]  st_be;
  logic [31:0] st_data;
  always_comb begin
    if (b_q) begin
      st_be   = 4'b0001 << adr_q[1:0];
      st_data = {4{wdata_q[7:0]}};
    end else if (half_q) begin
      st_be   = adr_q[1] ? 4'b1100 : 4'b0011;
      st_data = {2{wdata_q[15:0]}};
    end else begin
      st_be   = 4'b1111;
      st_data = wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (memwrite != CodeIdle) begin
          state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      code_q     <= CodeIdle;
      half_q     <= 1'b0;
      b_q        <= 1'b0;
      uns_q      <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_idle && (memwrite != CodeIdle)) begin
        code_q  <= memwrite;
        half_q  <= half;
        b_q     <= b;
        uns_q   <= bunsigned;
        adr_q   <= dataadr[AW+1:0];
        wdata_q <= writedata;
      end
      if (in_idle && (state_d == StWait)) begin
        cnt_q <= CntInit;
      end else if ((state_q == StWait) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if ((state_q != StResp) && (state_d == StResp) && (e_code == CodeLoad)) begin
        readdata_q <= req_err(e_code, e_half, e_b, e_adr[1:0]) ? 32'h0 : ld_ext;
      end
    end
  end

  // Array is not reset; a store commits at the edge that ends RESP.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == StResp) && (code_q == CodeStore) &&
        !req_err(code_q, half_q, b_q, adr_q[1:0])) begin
      for (int k = 0; k < 4; k++) begin
        if (st_be[k]) begin
          mem[adr_q[AW+1:2]][8*k +: 8] <= st_data[8*k +: 8];
        end
      end
    end
  end

  assign readdata = readdata_q;
  assign ready    = (state_q == StResp);
  assign err      = ready && req_err(code_q, half_q, b_q, adr_q[1:0]);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none,
// both driven by the same request bus.
module tb_dmem_responder;

  localparam logic [1:0] ST  = 2'b01;
  localparam logic [1:0] LD  = 2'b10;
  localparam logic [1:0] ILL = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  memwrite;
  logic        half, b, bunsigned;
  logic [31:0] dataadr, writedata;
  logic [31:0] rd2, rd0;
  logic        rdy2, rdy0, err2, err0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset), .memwrite(memwrite), .half(half), .b(b),
    .bunsigned(bunsigned), .dataadr(dataadr), .writedata(writedata),
    .readdata(rd2), .ready(rdy2), .err(err2)
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .memwrite(memwrite), .half(half), .b(b),
    .bunsigned(bunsigned), .dataadr(dataadr), .writedata(writedata),
    .readdata(rd0), .ready(rdy0), .err(err0)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one request just after a rising edge; sel=1 observes the zero-wait instance.
  task automatic req(input string tag, input bit sel, input logic [1:0] code,
                     input logic h, input logic bb, input logic u,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                     input bit chk_rd);
    int lat;
    logic [31:0] rd;
    logic e;
    lat = -1;
    rd = '0;
    e = 1'b0;
    memwrite = code; half = h; b = bb; bunsigned = u; dataadr = a; writedata = wd;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sel ? rdy0 : rdy2) begin
        lat = k;
        rd = sel ? rd0 : rd2;
        e = sel ? err0 : err2;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " err"}, {31'b0, e}, {31'b0, exp_err});
    if (chk_rd) check({tag, " readdata"}, rd, exp_rd);
    @(posedge clk);
    #1;
    memwrite = 2'b00;
  endtask

  initial begin
    logic seen;
    reset = 1'b1; memwrite = 2'b00; half = 1'b0; b = 1'b0; bunsigned = 1'b0;
    dataadr = '0; writedata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready", {31'b0, rdy2}, 32'h0);
    check("reset err", {31'b0, err2}, 32'h0);
    check("reset readdata", rd2, 32'h0);
    check("reset ready w0", {31'b0, rdy0}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Two-wait-state instance: ready in cycle 3.
    req("st w 10", 0, ST, 0, 0, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 3, 0);
    req("ld w 10", 0, LD, 0, 0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 1);
    req("st b 11", 0, ST, 0, 1, 0, 32'h11, 32'hAAAAAA7F, 32'h0, 0, 3, 0);
    req("ld w 10b", 0, LD, 0, 0, 0, 32'h10, 32'h0, 32'hDEAD7FEF, 0, 3, 1);
    req("ld bs 13", 0, LD, 0, 1, 0, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 3, 1);
    req("ld bu 13", 0, LD, 0, 1, 1, 32'h13, 32'h0, 32'h000000DE, 0, 3, 1);
    req("st w 20", 0, ST, 0, 0, 0, 32'h20, 32'h12345678, 32'h0, 0, 3, 0);
    req("st h 22", 0, ST, 1, 0, 0, 32'h22, 32'h55558001, 32'h0, 0, 3, 0);
    req("ld hs 22", 0, LD, 1, 0, 0, 32'h22, 32'h0, 32'hFFFF8001, 0, 3, 1);
    req("ld hu 22", 0, LD, 1, 0, 1, 32'h22, 32'h0, 32'h00008001, 0, 3, 1);
    req("ld w 20", 0, LD, 0, 0, 0, 32'h20, 32'h0, 32'h80015678, 0, 3, 1);

    // Error requests: flagged with ready, no array write, error load returns 0.
    req("ld h 21 err", 0, LD, 1, 0, 0, 32'h21, 32'h0, 32'h0, 1, 3, 1);
    req("st w 12 err", 0, ST, 0, 0, 0, 32'h12, 32'h0, 32'h0, 1, 3, 0);
    req("code 11 err", 0, ILL, 0, 0, 0, 32'h20, 32'hFFFFFFFF, 32'h0, 1, 3, 0);
    req("ld w 10 kept", 0, LD, 0, 0, 0, 32'h10, 32'h0, 32'hDEAD7FEF, 0, 3, 1);
    req("ld w 20 kept", 0, LD, 0, 0, 0, 32'h20, 32'h0, 32'h80015678, 0, 3, 1);

    // Reset during WAIT drops the pending store.
    req("st w 30", 0, ST, 0, 0, 0, 32'h30, 32'h11223344, 32'h0, 0, 3, 0);
    req("ld w 30", 0, LD, 0, 0, 0, 32'h30, 32'h0, 32'h11223344, 0, 3, 1);
    memwrite = ST; half = 1'b0; b = 1'b0; dataadr = 32'h30; writedata = 32'hAAAAAAAA;
    @(posedge clk);
    #1;
    reset = 1'b1;
    memwrite = 2'b00;
    @(negedge clk);
    seen = rdy2;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      seen = seen | rdy2;
    end
    check("reset in wait ready", {31'b0, seen}, 32'h0);
    check("reset in wait readdata", rd2, 32'h0);
    @(posedge clk);
    #1;
    req("ld w 30 after reset", 0, LD, 0, 0, 0, 32'h30, 32'h0, 32'h11223344, 0, 3, 1);

    // Zero-wait instance: wrap-around alias and back-to-back throughput.
    @(posedge clk);
    #1;
    req("w0 st w 100", 1, ST, 0, 0, 0, 32'h100, 32'hCAFEF00D, 32'h0, 0, 1, 0);
    req("w0 ld w 0", 1, LD, 0, 0, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0, 1, 1);
    memwrite = LD; half = 1'b0; b = 1'b0; dataadr = 32'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("w0 b2b ready c%0d", k), {31'b0, rdy0}, 32'(k % 2));
    end
    @(posedge clk);
    #1;
    memwrite = 2'b00;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the processor's data-memory port. It accepts load and store requests carrying `memwrite`, `half`, `b`, `bunsigned`, `dataadr` and `writedata`, and performs byte, halfword or word access on an internal word array. Loads return sign- or zero-extended data. Completion is signalled through a `ready` handshake after a programmable number of wait states, so the pipeline can be verified against a memory that stalls. It takes the place of the single-cycle data memory beside `mips` under the top level.

## Interface
- `DEPTH`, 64: number of 32-bit words in the array; power of two, at least 4.
- `WAIT_CYCLES`, 2: wait states between acceptance and response; 0 to 15.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `memwrite` input 2: request code. 2'b00 idle, 2'b01 store, 2'b10 load, 2'b11 illegal.
- `half` input 1: halfword access.
- `b` input 1: byte access; takes priority over `half`. Neither set means word access.
- `bunsigned` input 1: zero-extend loads when 1, sign-extend when 0.
- `dataadr` input 32: byte address.
- `writedata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `readdata` output 32: load result.
- `ready` output 1: one-cycle pulse marking request completion.
- `err` output 1: one-cycle pulse with `ready` on an illegal or misaligned request.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: with `memwrite` != 0, the accepting edge captures all request inputs into holding registers. Next state is WAIT, or RESP directly when `WAIT_CYCLES`=0. Input changes after acceptance are ignored.
- WAIT: a 4-bit counter loads `WAIT_CYCLES`-1 on entry and decrements each cycle. The FSM moves to RESP at the edge where the counter is 0.
- RESP: `ready`=1 for exactly this cycle. Next state is always IDLE.
- Word index is `adr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Lanes are little-endian: byte k of a word is bits [8k+7:8k].
- Store byte writes `writedata[7:0]` into lane `adr[1:0]`.
- Store half writes `writedata[15:0]` into lanes {2*`adr[1]`+1, 2*`adr[1]`}.
- Store word writes all 4 lanes.
- Other lanes are preserved (read-modify-write via byte enables).
- Store commit: the array updates at the edge ending RESP. A load in the very next request observes the new data.
- Load: `readdata` is registered on entry to RESP with the extracted lane data, extended per captured `bunsigned`. It holds until the next load enters RESP; stores and errors do not change it, except that an error load drives 0.
- Error cases: code 2'b11; half with `adr[0]`=1; word with `adr[1:0]`!=0.
  - `err`=1 in the RESP cycle.
  - No array write occurs.
  - For an error load, `readdata`=0.
- Array contents are not reset. Simulation initial value is X, with optional preload by the bench.

## Timing
- Reset values: state IDLE, `ready`=0, `err`=0, `readdata`=0, counter 0.
- Latency: a request first seen in IDLE at cycle 0 gets `ready` in cycle `WAIT_CYCLES`+1.
- Throughput: one request per `WAIT_CYCLES`+2 cycles. IDLE always occupies one cycle between requests.
- Requester contract: hold the request stable until `ready`, then drop it or present the next one at the edge where `ready` is sampled high. A request held unchanged past that edge is accepted again as a new request.
- Reset in WAIT or RESP returns to IDLE. The pending store is dropped, and `ready`, `err` and `readdata` clear on the next cycle.
- `ready` and `err` never assert outside RESP.

## Test plan
- WAIT_CYCLES=2. Store word 0xDEADBEEF @0x10, then load word @0x10 → `ready` at cycle 3 of each request, `readdata`=0xDEADBEEF, `err`=0.
- Store byte 0x7F @0x11 over 0xDEADBEEF, then load word → 0xDEAD7FEF.
  - Load byte signed @0x13 → 0xFFFFFFDE.
  - Load byte unsigned @0x13 → 0x000000DE.
- Store half 0x8001 @0x22, then:
  - Load half signed @0x22 → 0xFFFF8001.
  - Load half unsigned @0x22 → 0x00008001.
  - Load word @0x20 → upper half 0x8001, lower half unchanged.
- Load half @0x21, store word @0x12, `memwrite`=2'b11 → each gives `err`=1 with `ready`, no array change, and `readdata`=0 on the error load.
- WAIT_CYCLES=0 with back-to-back requests → `ready` every 2nd cycle. DEPTH=64 wrap: store @0x100 aliases word 0, confirmed by a load @0x0.
- Assert `reset` during WAIT of a store @0x30 → `ready` never pulses, and a later load @0x30 returns the previous contents.
